// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a direct-mapped table of 2-bit saturating counters with
// branch targets, trained by resolved conditional branches, plus branch/mispredict counters.
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pred_pc_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic [2:0]  upd_funct3_i,
  input  logic        upd_br_less_i,
  input  logic        upd_br_equal_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_pred_taken_i,
  output logic        upd_taken_o,
  output logic        upd_mispredict_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispredict_cnt_o
);

  localparam int IDX = $clog2(ENTRIES);

  logic [1:0]         ctr_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [ENTRIES-1:0] valid_q;
  logic [31:0]        branch_cnt_q;
  logic [31:0]        mispredict_cnt_q;

  logic [IDX-1:0] pred_idx;
  logic [IDX-1:0] upd_idx;
  logic           funct3_legal;
  logic           cond_taken;
  logic           upd_en;
  logic           unused_upd_pc;

  assign pred_idx      = pred_pc_i[IDX+1:2];
  assign upd_idx       = upd_pc_i[IDX+1:2];
  assign unused_upd_pc = ^{upd_pc_i[31:IDX+2], upd_pc_i[1:0]};

  // Prediction reads the registered table only, so a same-cycle update to the
  // same entry becomes visible one cycle later.
  assign pred_taken_o  = ctr_q[pred_idx][1] & valid_q[pred_idx];
  assign pred_target_o = valid_q[pred_idx] ? target_q[pred_idx] : pred_pc_i + 32'd4;

  always_comb begin
    funct3_legal = 1'b1;
    cond_taken   = 1'b0;
    case (upd_funct3_i)
      3'b000:  cond_taken = upd_br_equal_i;
      3'b001:  cond_taken = ~upd_br_equal_i;
      3'b100:  cond_taken = upd_br_less_i;
      3'b101:  cond_taken = ~upd_br_less_i;
      3'b110:  cond_taken = upd_br_less_i;
      3'b111:  cond_taken = ~upd_br_less_i;
      default: funct3_legal = 1'b0;
    endcase
  end

  // Update side is a one-cycle strobe: upd_valid_i high means one resolved
  // branch is presented this cycle and is consumed at the next rising edge;
  // there is no ready, the predictor always accepts.
  assign upd_en           = upd_valid_i & funct3_legal;
  assign upd_taken_o      = upd_en & cond_taken;
  assign upd_mispredict_o = upd_en & (cond_taken ^ upd_pred_taken_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i]    <= 2'b01;
        target_q[i] <= 32'd0;
      end
      valid_q          <= '0;
      branch_cnt_q     <= 32'd0;
      mispredict_cnt_q <= 32'd0;
    end else if (upd_en) begin
      branch_cnt_q <= branch_cnt_q + 32'd1;
      if (upd_mispredict_o) begin
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end
      if (cond_taken) begin
        if (ctr_q[upd_idx] != 2'b11) begin
          ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'b01;
        end
        target_q[upd_idx] <= upd_target_i;
        valid_q[upd_idx]  <= 1'b1;
      end else if (ctr_q[upd_idx] != 2'b00) begin
        ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'b01;
      end
    end
  end

  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: each step drives one cycle of inputs and queues
// the hand-computed outputs; a negedge monitor pops and compares them.
module tb_branch_predictor;

  localparam int W = 99;

  logic        clk;
  logic        rst_n;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [2:0]  upd_funct3;
  logic        upd_br_less;
  logic        upd_br_equal;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic        upd_taken;
  logic        upd_mispredict;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  logic        obs_valid;
  logic [W-1:0] exp_q[$];
  int          checks;
  int          errors;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .pred_pc_i        (pred_pc),
    .pred_taken_o     (pred_taken),
    .pred_target_o    (pred_target),
    .upd_valid_i      (upd_valid),
    .upd_pc_i         (upd_pc),
    .upd_funct3_i     (upd_funct3),
    .upd_br_less_i    (upd_br_less),
    .upd_br_equal_i   (upd_br_equal),
    .upd_target_i     (upd_target),
    .upd_pred_taken_i (upd_pred_taken),
    .upd_taken_o      (upd_taken),
    .upd_mispredict_o (upd_mispredict),
    .branch_cnt_o     (branch_cnt),
    .mispredict_cnt_o (mispredict_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard compare
  task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // monitor: samples on the falling edge, mid-cycle
  always @(negedge clk) begin
    if (obs_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL monitor at %0t: output presented with empty expected queue", $time);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check_field("pred_taken",     {31'd0, pred_taken},     {31'd0, e[98]});
        check_field("pred_target",    pred_target,             e[97:66]);
        check_field("upd_taken",      {31'd0, upd_taken},      {31'd0, e[65]});
        check_field("upd_mispredict", {31'd0, upd_mispredict}, {31'd0, e[64]});
        check_field("branch_cnt",     branch_cnt,              e[63:32]);
        check_field("mispredict_cnt", mispredict_cnt,          e[31:0]);
      end
    end
  end

  // driver: one cycle of inputs; expected outputs are those before the next edge commits
  task automatic step(input logic chk, input logic rst, input logic [31:0] ppc,
                      input logic uv, input logic [31:0] upc, input logic [2:0] f3,
                      input logic less, input logic eq, input logic [31:0] tgt,
                      input logic upred, input logic e_pt, input logic [31:0] e_ptgt,
                      input logic e_ut, input logic e_um, input logic [31:0] e_bc,
                      input logic [31:0] e_mc);
    @(posedge clk);
    #2;
    rst_n          = rst;
    pred_pc        = ppc;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_funct3     = f3;
    upd_br_less    = less;
    upd_br_equal   = eq;
    upd_target     = tgt;
    upd_pred_taken = upred;
    if (chk) begin
      exp_q.push_back({e_pt, e_ptgt, e_ut, e_um, e_bc, e_mc});
      obs_valid = 1'b1;
    end else begin
      obs_valid = 1'b0;
    end
  endtask

  task automatic predict(input logic [31:0] ppc, input logic e_pt, input logic [31:0] e_ptgt,
                         input logic [31:0] e_bc, input logic [31:0] e_mc);
    step(1'b1, 1'b1, ppc, 1'b0, 32'd0, 3'b000, 1'b0, 1'b0, 32'd0, 1'b0,
         e_pt, e_ptgt, 1'b0, 1'b0, e_bc, e_mc);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    obs_valid = 1'b0;
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // reset state
    predict(32'h100, 1'b0, 32'h104, 32'd0, 32'd0);
    // BEQ taken, mispredicted; same-cycle prediction sees pre-update state
    step(1'b1, 1'b1, 32'h100, 1'b1, 32'h100, 3'b000, 1'b0, 1'b1, 32'h80, 1'b0,
         1'b0, 32'h104, 1'b1, 1'b1, 32'd0, 32'd0);
    predict(32'h100, 1'b1, 32'h80, 32'd1, 32'd1);
    predict(32'h140, 1'b1, 32'h80, 32'd1, 32'd1);   // aliases entry 0
    // illegal funct3 010 is ignored
    step(1'b1, 1'b1, 32'h100, 1'b1, 32'h100, 3'b010, 1'b1, 1'b1, 32'h999, 1'b1,
         1'b1, 32'h80, 1'b0, 1'b0, 32'd1, 32'd1);
    predict(32'h100, 1'b1, 32'h80, 32'd1, 32'd1);

    // four taken BLT to 0x104 then two not-taken BGE
    step(1'b1, 1'b1, 32'h104, 1'b1, 32'h104, 3'b100, 1'b1, 1'b0, 32'h40, 1'b0,
         1'b0, 32'h108, 1'b1, 1'b1, 32'd1, 32'd1);
    step(1'b1, 1'b1, 32'h104, 1'b1, 32'h104, 3'b100, 1'b1, 1'b0, 32'h40, 1'b1,
         1'b1, 32'h40, 1'b1, 1'b0, 32'd2, 32'd2);
    step(1'b1, 1'b1, 32'h104, 1'b1, 32'h104, 3'b100, 1'b1, 1'b0, 32'h40, 1'b1,
         1'b1, 32'h40, 1'b1, 1'b0, 32'd3, 32'd2);
    step(1'b1, 1'b1, 32'h104, 1'b1, 32'h104, 3'b100, 1'b1, 1'b0, 32'h40, 1'b1,
         1'b1, 32'h40, 1'b1, 1'b0, 32'd4, 32'd2);
    step(1'b1, 1'b1, 32'h104, 1'b1, 32'h104, 3'b101, 1'b1, 1'b0, 32'h777, 1'b1,
         1'b1, 32'h40, 1'b0, 1'b1, 32'd5, 32'd2);
    step(1'b1, 1'b1, 32'h104, 1'b1, 32'h104, 3'b101, 1'b1, 1'b0, 32'h777, 1'b1,
         1'b1, 32'h40, 1'b0, 1'b1, 32'd6, 32'd3);
    predict(32'h104, 1'b0, 32'h40, 32'd7, 32'd4);   // counter back to 01, target kept
    predict(32'h100, 1'b1, 32'h80, 32'd7, 32'd4);   // other entry untouched

    // remaining outcome decodes on 0x108
    step(1'b1, 1'b1, 32'h108, 1'b1, 32'h108, 3'b001, 1'b0, 1'b0, 32'h300, 1'b0,
         1'b0, 32'h10C, 1'b1, 1'b1, 32'd7, 32'd4);
    step(1'b1, 1'b1, 32'h108, 1'b1, 32'h108, 3'b110, 1'b0, 1'b0, 32'h555, 1'b1,
         1'b1, 32'h300, 1'b0, 1'b1, 32'd8, 32'd5);
    step(1'b1, 1'b1, 32'h108, 1'b1, 32'h108, 3'b111, 1'b0, 1'b0, 32'h300, 1'b0,
         1'b0, 32'h300, 1'b1, 1'b1, 32'd9, 32'd6);
    step(1'b1, 1'b1, 32'h108, 1'b1, 32'h108, 3'b000, 1'b0, 1'b0, 32'h666, 1'b0,
         1'b1, 32'h300, 1'b0, 1'b0, 32'd10, 32'd7);
    // not-taken into a fresh entry leaves it invalid
    step(1'b1, 1'b1, 32'h10C, 1'b1, 32'h10C, 3'b001, 1'b0, 1'b1, 32'h888, 1'b0,
         1'b0, 32'h110, 1'b0, 1'b0, 32'd11, 32'd7);
    predict(32'h10C, 1'b0, 32'h110, 32'd12, 32'd7);
    step(1'b1, 1'b1, 32'h108, 1'b1, 32'h108, 3'b011, 1'b1, 1'b1, 32'h123, 1'b1,
         1'b0, 32'h300, 1'b0, 1'b0, 32'd12, 32'd7);
    // upd_valid low gates outputs
    step(1'b1, 1'b1, 32'h108, 1'b0, 32'h108, 3'b000, 1'b0, 1'b1, 32'h123, 1'b0,
         1'b0, 32'h300, 1'b0, 1'b0, 32'd12, 32'd7);
    predict(32'h10C, 1'b0, 32'h110, 32'd12, 32'd7);

    // reset wins over a concurrent taken update to 0x200
    step(1'b0, 1'b0, 32'h200, 1'b1, 32'h200, 3'b000, 1'b0, 1'b1, 32'h500, 1'b0,
         1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
    predict(32'h200, 1'b0, 32'h204, 32'd0, 32'd0);
    predict(32'h100, 1'b0, 32'h104, 32'd0, 32'd0);

    // mispredict counter wrap
    @(negedge clk);
    #1;
    force dut.mispredict_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.mispredict_cnt_q;
    step(1'b1, 1'b1, 32'h100, 1'b1, 32'h100, 3'b000, 1'b0, 1'b1, 32'h80, 1'b0,
         1'b0, 32'h104, 1'b1, 1'b1, 32'd0, 32'hFFFF_FFFF);
    predict(32'h100, 1'b1, 32'h80, 32'd1, 32'd0);

    @(posedge clk);
    #2;
    obs_valid = 1'b0;
    upd_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter: ENTRIES, default 16, number of table entries (power of two, 2..256); IDX = log2(ENTRIES).
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, synchronous, active-low.
REQ-004 pred_pc_i  input  32  fetch PC to predict.
REQ-005 pred_taken_o  output  1  predicted taken for pred_pc_i.
REQ-006 pred_target_o  output  32  predicted target for pred_pc_i.
REQ-007 upd_valid_i  input  1  resolved conditional branch present this cycle.
REQ-008 upd_pc_i  input  32  PC of resolved branch.
REQ-009 upd_funct3_i  input  3  branch funct3 of resolved branch.
REQ-010 upd_br_less_i  input  1  comparator less flag, signedness already selected by funct3.
REQ-011 upd_br_equal_i  input  1  comparator equal flag.
REQ-012 upd_target_i  input  32  computed branch target.
REQ-013 upd_pred_taken_i  input  1  prediction made at fetch for this branch.
REQ-014 upd_taken_o  output  1  resolved outcome (combinational).
REQ-015 upd_mispredict_o  output  1  resolved outcome differs from prediction (combinational).
REQ-016 branch_cnt_o  output  32  count of valid resolved branches.
REQ-017 mispredict_cnt_o  output  32  count of mispredictions.

Function
REQ-018 Index: pred side pred_pc_i[IDX+1:2]; update side upd_pc_i[IDX+1:2]; no tags, aliasing permitted.
REQ-019 State per entry: 2-bit counter (00 SNT, 01 WNT, 10 WT, 11 ST), valid bit, 32-bit target.
REQ-020 Outcome decode: 000 BEQ=equal; 001 BNE=!equal; 100 BLT=less; 101 BGE=!less; 110 BLTU=less; 111 BGEU=!less.
REQ-021 funct3 010/011 illegal: upd_taken_o=0, upd_mispredict_o=0, no table or counter change.
REQ-022 upd_taken_o and upd_mispredict_o = 0 whenever upd_valid_i=0.
REQ-023 Prediction combinational from current state: pred_taken_o = counter[1] AND valid; pred_target_o = stored target when valid, else pred_pc_i+4.
REQ-024 Valid legal update, taken: counter increments, saturates at 11; target <= upd_target_i; valid <= 1; all next edge.
REQ-025 Valid legal update, not taken: counter decrements, saturates at 00; target and valid unchanged.
REQ-026 upd_mispredict_o = upd_taken_o XOR upd_pred_taken_i for valid legal updates.
REQ-027 branch_cnt_o increments by 1 per valid legal update; mispredict_cnt_o increments when upd_mispredict_o=1; both wrap 0xFFFFFFFF -> 0.
REQ-028 Same-cycle read/write same index: prediction uses pre-update state; new state visible next cycle.
REQ-029 At most one update per cycle; the update alters only its indexed entry.

Reset
REQ-030 While rst_ni=0 at a clock edge: all counters <= 01, all valid <= 0, all targets <= 0, branch_cnt_o and mispredict_cnt_o <= 0.
REQ-031 Reset overrides a concurrent update; the update is lost.
REQ-032 After reset, pred_taken_o=0 and pred_target_o=pred_pc_i+4 for every PC.

Verification
REQ-033 Reset, pred_pc_i=0x100 -> pred_taken_o=0, pred_target_o=0x104, both counts 0.
REQ-034 Update pc=0x100, funct3=000, equal=1, target=0x80, pred=0 -> upd_taken_o=1, mispredict=1; next cycle pred_pc_i=0x100 -> taken=1, target=0x80, branch_cnt=1, mispredict_cnt=1.
REQ-035 Four taken BLT updates (less=1) to same PC, then two BGE not-taken (less=1) -> counter 11 then 01; pred_taken_o=0 after second not-taken.
REQ-036 Update funct3=010 with upd_valid_i=1 -> outputs 0, counts and tables unchanged.
REQ-037 ENTRIES=16: update pc=0x100 taken, then predict pc=0x140 (alias) -> pred_taken_o=1, pred_target_o equals 0x100's stored target.
REQ-038 Taken update to 0x200 with rst_ni=0 same edge -> next cycle pred_taken_o=0 for 0x200, counts 0; preset mispredict_cnt to 0xFFFFFFFF via 2^32 mispredicts or force -> one more mispredict wraps to 0.
